// File: rtl/decoder_38_pkg.sv
// Shared widths, idle value and one-hot helper for the registered 3-to-8 decoder.
// Macro DECODER_38_ACTIVE_LOW_OUT_EN selects active-low (74x138 style) outputs.
package decoder_38_pkg;

    localparam int unsigned IN_W  = 3;
    localparam int unsigned OUT_W = 1 << IN_W;

`ifdef DECODER_38_ACTIVE_LOW_OUT_EN
    localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{1'b1}};
`else
    localparam logic [OUT_W-1:0] OUT_IDLE = '0;
`endif

    // Active-high one-hot code for a binary select.
    function automatic logic [OUT_W-1:0] onehot_dec(input logic [IN_W-1:0] sel);
        onehot_dec = OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/decoder_38_comb.sv
// Pure combinational enable-gated binary to one-hot decode (active high).
module decoder_38_comb
    import decoder_38_pkg::*;
(
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_W-1:0] dec_c
);

    // Gate the one-hot code with the enable.
    always_comb begin
        dec_c = '0;
        if (en) begin
            dec_c = onehot_dec(in);
        end
    end

endmodule

// File: rtl/decoder_38.sv
// Registered 3-to-8 one-hot decoder with active-high enable.
// Macro DECODER_38_ACTIVE_LOW_OUT_EN: outputs become active low, idle/reset value all ones.
module decoder_38
    import decoder_38_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    input  logic             en
);

    logic [OUT_W-1:0] dec_c;
    logic [OUT_W-1:0] out_d_c;
    logic [OUT_W-1:0] out_act_c;
    logic             en_q;

    decoder_38_comb u_comb (
        .in    (in),
        .en    (en),
        .dec_c (dec_c)
    );

    // Apply output polarity before the register so the flop output is glitch-free.
`ifdef DECODER_38_ACTIVE_LOW_OUT_EN
    assign out_d_c   = ~dec_c;
    assign out_act_c = ~out;
`else
    assign out_d_c   = dec_c;
    assign out_act_c = out;
`endif

    // Output register, cleared to the idle value asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= OUT_IDLE;
        end else begin
            out <= out_d_c;
        end
    end

    // Enable as seen by the current output, used only by the invariant below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    // At most one active output; exactly one when the captured enable was high.
    always_ff @(negedge clk) begin
        if (rst_n) begin
            assert ($onehot0(out_act_c));
            assert (!en_q || $onehot(out_act_c));
        end
    end

endmodule

// File: tb/tb_decoder_38.sv
// Self-checking bench for decoder_38: directed sweeps plus random traffic vs. a reference model.
module tb_decoder_38;

    logic       clk;
    logic       rst_n;
    logic [2:0] in;
    logic [7:0] out;
    logic       en;

    int checks;
    int failures;

    decoder_38 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out),
        .en    (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output from the decode rule: bit number sel is active when enabled.
    function automatic logic [7:0] ref_out(input bit e, input int sel);
        logic [7:0] v;
        v = 8'h00;
        if (e) v = 8'(2 ** sel);
`ifdef DECODER_38_ACTIVE_LOW_OUT_EN
        v = ~v;
`endif
        return v;
    endfunction

    function automatic logic [7:0] idle_val();
        return ref_out(1'b0, 0);
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one {en,in} pair at the falling edge, check the result just after the next rising edge.
    task automatic step(input string tag, input bit e, input int sel);
        logic [7:0] exp;
        logic [7:0] act;
        @(negedge clk);
        en = e;
        in = 3'(sel);
        exp = ref_out(e, sel);
        @(posedge clk);
        #1;
        check(tag, out, exp);
`ifdef DECODER_38_ACTIVE_LOW_OUT_EN
        act = ~out;
`else
        act = out;
`endif
        check({tag, "_ones"}, 8'($countones(act)), e ? 8'd1 : 8'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 3'd5;

        // Reset with no clock edge yet: output already idle.
        #2;
        check("reset_no_edge", out, idle_val());
        @(posedge clk);
        #1;
        check("reset_held", out, idle_val());

        // Release and decode in=5 on the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", out, ref_out(1'b1, 5));

        for (int i = 0; i < 8; i++) step("dis_sweep", 1'b0, i);
        for (int i = 0; i < 8; i++) step("en_sweep", 1'b1, i);
        for (int i = 0; i < 16; i++) step("walk", i >= 8, i % 8);

        // Enable drops while in stays 3.
        step("toggle_on", 1'b1, 3);
        step("toggle_off", 1'b0, 3);

        // Reset pulse between edges clears immediately, decoding resumes afterwards.
        step("pre_reset", 1'b1, 6);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_clear", out, idle_val());
        #1;
        rst_n = 1'b1;
        check("async_hold", out, idle_val());
        step("resume", 1'b1, 2);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
